// File: rtl/g1_chain_search.sv
// G1 rule-table search: walks next-index chains from a start entry until a src/dst key
// match, a NULL/out-of-range pointer or the hop limit; table writes are taken only while idle.
module g1_chain_search #(
  parameter int    INDEX_BIT_LEN  = 11,
  parameter int    TABLE_DEPTH    = 155,
  parameter int    KEY_W          = 32,
  parameter int    PACKET_BIT_LEN = 104,
  parameter int    MAX_HOPS       = 8,
  parameter string INIT_FILE      = "",
  localparam int   ENTRY_W        = 1 + 2*INDEX_BIT_LEN + 2*KEY_W,
  localparam int   HOP_W          = $clog2(MAX_HOPS+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [INDEX_BIT_LEN-1:0]  req_index,
  input  logic [PACKET_BIT_LEN-1:0] req_tuple,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_match,
  output logic [INDEX_BIT_LEN-1:0]  rsp_rule_id,
  output logic [HOP_W-1:0]          rsp_hops,
  output logic [INDEX_BIT_LEN-1:0]  rsp_last_index,
  input  logic                      wr_en,
  output logic                      wr_ready,
  input  logic [INDEX_BIT_LEN-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0]        wr_data
);
  localparam int IW = INDEX_BIT_LEN;
  localparam int AW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
  localparam logic [IW-1:0]    DEPTH_I = IW'(TABLE_DEPTH);
  localparam logic [HOP_W-1:0] HOP_M1  = HOP_W'(MAX_HOPS-1);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_RESP} state_t;
  state_t r_state, w_nstate;

  logic [ENTRY_W-1:0] r_mem [TABLE_DEPTH];
  logic [IW-1:0]      r_cur, r_last, r_rule;
  logic [KEY_W-1:0]   r_src, r_dst;
  logic [HOP_W-1:0]   r_hops;
  logic               r_match, r_live;

  logic               w_cur_ok, w_hit, w_end, w_accept, w_req_ok, w_wr, w_unused;
  logic [ENTRY_W-1:0] w_ent;
  logic               w_valid;
  logic [IW-1:0]      w_next, w_rule;
  logic [KEY_W-1:0]   w_skey, w_dkey;

  assign w_cur_ok = r_cur < DEPTH_I;
  assign w_ent    = w_cur_ok ? r_mem[r_cur[AW-1:0]] : '0;
  assign w_valid  = w_ent[ENTRY_W-1];
  assign w_next   = w_ent[ENTRY_W-2 -: IW];
  assign w_rule   = w_ent[2*KEY_W +: IW];
  assign w_dkey   = w_ent[KEY_W +: KEY_W];
  assign w_skey   = w_ent[0 +: KEY_W];
  assign w_hit    = w_cur_ok && w_valid && (w_skey == r_src) && (w_dkey == r_dst);
  // An out-of-range next pointer ends the walk like NULL (NULL is itself >= depth), so
  // every visited cycle examines a real entry and latency stays hops+1.
  assign w_end    = !w_cur_ok || w_hit || (w_next >= DEPTH_I) || (r_hops == HOP_M1);
  assign w_accept = req_valid && req_ready;
  assign w_req_ok = req_index < DEPTH_I;
  assign w_wr     = wr_en && wr_ready && (wr_addr < DEPTH_I);
  assign w_unused = ^req_tuple;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_nstate = w_req_ok ? S_WALK : S_RESP;
      S_WALK: if (w_end) w_nstate = S_RESP;
      S_RESP: if (rsp_ready) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        wr_ready  = 1'b1;
        req_ready = r_live && !wr_en;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live  <= 1'b0;
      r_cur   <= '0;
      r_last  <= '0;
      r_rule  <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_hops  <= '0;
      r_match <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_cur   <= req_index;
        r_last  <= req_index;
        r_src   <= req_tuple[0 +: KEY_W];
        r_dst   <= req_tuple[KEY_W +: KEY_W];
        r_hops  <= '0;
        r_match <= 1'b0;
        r_rule  <= '0;
      end else if (r_state == S_WALK && w_cur_ok) begin
        r_hops <= r_hops + 1'b1;
        r_last <= r_cur;
        if (w_hit) begin
          r_match <= 1'b1;
          r_rule  <= w_rule;
        end else if (!w_end) begin
          r_cur <= w_next;
        end
      end
    end
  end

  // Table storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[wr_addr[AW-1:0]] <= wr_data;
  end

  assign rsp_match      = r_match;
  assign rsp_rule_id    = r_rule;
  assign rsp_hops       = r_hops;
  assign rsp_last_index = r_last;
endmodule

// File: tb/tb_g1_chain_search.sv
// Directed bench for g1_chain_search: single hits, chains, misses, loops, write priority,
// response back-pressure, reset abort and dropped out-of-range writes.
module tb_g1_chain_search;
  localparam logic [10:0] NUL = 11'h7FF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_ready;
  logic [10:0]  req_index = '0;
  logic [103:0] req_tuple = '0;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_match;
  logic [10:0]  rsp_rule_id, rsp_last_index;
  logic [3:0]   rsp_hops;
  logic         wr_en = 1'b0, wr_ready;
  logic [10:0]  wr_addr = '0;
  logic [86:0]  wr_data = '0;

  int n_chk = 0;
  int n_err = 0;

  g1_chain_search dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_tuple(req_tuple),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_match(rsp_match),
    .rsp_rule_id(rsp_rule_id), .rsp_hops(rsp_hops), .rsp_last_index(rsp_last_index),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [86:0] ent(input logic v, input logic [10:0] nx, input logic [10:0] rl,
                                      input logic [31:0] d, input logic [31:0] s);
    return {v, nx, rl, d, s};
  endfunction

  task automatic wr(input logic [10:0] a, input logic [86:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    #1 chk("wr_ready", wr_ready, 1'b1);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issues one search with rsp_ready high and checks the whole response.
  task automatic search(input string tag, input logic [10:0] idx, input logic [31:0] s,
                        input logic [31:0] d, input logic em, input logic [10:0] erule,
                        input logic [3:0] ehops, input logic [10:0] elast, input int elat);
    int n, lat;
    @(negedge clk);
    req_valid = 1'b1; req_index = idx; req_tuple = {40'h0, d, s};
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, ".accept"}, req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk({tag, ".rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".match"}, rsp_match, em);
    chk({tag, ".rule"}, rsp_rule_id, erule);
    chk({tag, ".hops"}, rsp_hops, ehops);
    chk({tag, ".last"}, rsp_last_index, elast);
    @(posedge clk); #1;
    chk({tag, ".rsp_drop"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    chk("rst.req_ready", req_ready, 1'b0);
    chk("rst.match", rsp_match, 1'b0);
    chk("rst.rule", rsp_rule_id, 11'd0);
    chk("rst.hops", rsp_hops, 4'd0);
    chk("rst.last", rsp_last_index, 11'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst.req_ready_before_clk", req_ready, 1'b0);
    @(posedge clk); #1;
    chk("rst.req_ready_after_clk", req_ready, 1'b1);

    // single-entry hit
    wr(11'd3, ent(1'b1, NUL, 11'd17, 32'h0A000001, 32'hC0A80001));
    search("t1", 11'd3, 32'hC0A80001, 32'h0A000001, 1'b1, 11'd17, 4'd1, 11'd3, 2);

    // chain 0 -> 5 -> 9, hit at 9
    wr(11'd0, ent(1'b1, 11'd5, 11'd1, 32'h1, 32'h1));
    wr(11'd5, ent(1'b1, 11'd9, 11'd2, 32'h2, 32'h2));
    wr(11'd9, ent(1'b1, NUL, 11'd42, 32'hBBBB, 32'hAAAA));
    search("t2", 11'd0, 32'hAAAA, 32'hBBBB, 1'b1, 11'd42, 4'd3, 11'd9, 4);

    // entry 5 invalid but keyed like the request: walked through, never matched
    wr(11'd5, ent(1'b0, 11'd9, 11'd7, 32'hBEEF, 32'hDEAD));
    search("t3", 11'd0, 32'hDEAD, 32'hBEEF, 1'b0, 11'd0, 4'd3, 11'd9, 4);

    // loop 2 <-> 4 stops at the hop limit; out-of-range start index
    wr(11'd2, ent(1'b1, 11'd4, 11'd3, 32'h1, 32'h1));
    wr(11'd4, ent(1'b1, 11'd2, 11'd4, 32'h1, 32'h1));
    search("t4loop", 11'd2, 32'h55, 32'h55, 1'b0, 11'd0, 4'd8, 11'd4, 9);
    search("t4oob", 11'd200, 32'h55, 32'h55, 1'b0, 11'd0, 4'd0, 11'd200, 1);

    // write and request in the same idle cycle: write wins, request waits
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 11'd7; wr_data = ent(1'b1, NUL, 11'd99, 32'h77, 32'h66);
    req_valid = 1'b1; req_index = 11'd7; req_tuple = {40'h0, 32'h77, 32'h66};
    rsp_ready = 1'b0;
    #1;
    chk("t5.req_ready_blocked", req_ready, 1'b0);
    chk("t5.wr_ready", wr_ready, 1'b1);
    @(posedge clk); #1;
    wr_en = 1'b0;
    #1 chk("t5.req_ready_after", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t5.walk_req_ready", req_ready, 1'b0);
    chk("t5.walk_wr_ready", wr_ready, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("t5.hold_valid", rsp_valid, 1'b1);
      chk("t5.hold_rule", rsp_rule_id, 11'd99);
      chk("t5.hold_match", rsp_match, 1'b1);
      chk("t5.hold_hops", rsp_hops, 4'd1);
      @(posedge clk); #1;
    end
    chk("t5.resp_wr_ready", wr_ready, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5.released", rsp_valid, 1'b0);

    // reset mid-walk aborts the search
    @(negedge clk);
    req_valid = 1'b1; req_index = 11'd2; req_tuple = {40'h0, 32'h55, 32'h55};
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6.rsp_valid", rsp_valid, 1'b0);
    chk("t6.hops", rsp_hops, 4'd0);
    chk("t6.wr_ready_idle", wr_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6.idle_again", req_ready, 1'b1);

    // out-of-range write is accepted and dropped (300 aliases 44 in the low bits)
    wr(11'd44, ent(1'b1, NUL, 11'd5, 32'h44, 32'h44));
    wr(11'd300, ent(1'b1, NUL, 11'd123, 32'h44, 32'h44));
    search("t6drop", 11'd44, 32'h44, 32'h44, 1'b1, 11'd5, 4'd1, 11'd44, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
